// File: rtl/data_mem_ctrl_if.sv
// Memory-side request/response bus of the data-memory controller.
// The master modport is the controller, the slave modport is the memory.
interface data_mem_ctrl_if;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [3:0]  mem_strb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_strb, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_strb, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: turns a single-cycle core load/store request into a
// valid/ready bus transaction, stalls the core until completion, and reports
// timeout (bus_err) and, optionally, misaligned accesses.
// Optional feature macro: MISALIGN_CHECK_EN (misaligned word/halfword accesses
// complete immediately with misalign=1 and never reach the bus).
module data_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req_i,
    input  logic                  core_we_re_i,
    input  logic [3:0]            core_mask_i,
    input  logic [31:0]           core_addr_i,
    input  logic [31:0]           core_wdata_i,
    output logic [31:0]           core_rdata_o,
    output logic                  core_stall_o,
    output logic                  core_valid_o,
    output logic                  bus_err_o,
    output logic                  misalign_o,
    data_mem_ctrl_if.master       mem
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Counter value of the last cycle allowed in REQ+RESP before aborting.
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 32'd1);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [3:0]  strb_q, strb_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        mis_q, mis_d;

    logic        timeout_s;
    logic        misalign_s;
    logic        mem_valid_s;
    logic        core_valid_s;
    logic        core_stall_s;

`ifdef MISALIGN_CHECK_EN
    // Word access needs addr[1:0]==0, halfword access needs addr[0]==0.
    function automatic logic is_misaligned(input logic [3:0] mask, input logic [1:0] lsb);
        logic bad;
        bad = 1'b0;
        if (mask == 4'b1111) begin
            bad = (lsb != 2'b00);
        end else if ((mask == 4'b0011) || (mask == 4'b1100)) begin
            bad = lsb[0];
        end else begin
            bad = 1'b0;
        end
        return bad;
    endfunction

    assign misalign_s = core_req_i & is_misaligned(core_mask_i, core_addr_i[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    // The current REQ/RESP cycle is the TIMEOUT_CYCLES-th one spent on this access.
    assign timeout_s = (cnt_q == TO_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a bus response takes priority over a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (core_req_i) begin
                    if ((core_mask_i == 4'b0000) || misalign_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem.mem_ready) begin
                    if (we_q || mem.mem_rvalid) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else if (timeout_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RESP: begin
                if (mem.mem_rvalid || timeout_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: request latch, load data, timeout counter, status flags.
    always_comb begin
        we_d    = we_q;
        strb_d  = strb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        mis_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (core_req_i) begin
                    we_d    = core_we_re_i;
                    strb_d  = core_mask_i;
                    addr_d  = core_addr_i;
                    wdata_d = core_wdata_i;
                    cnt_d   = 10'd0;
                    mis_d   = misalign_s;
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 10'd1;
                if (mem.mem_ready) begin
                    if (!we_q && mem.mem_rvalid) begin
                        rdata_d = mem.mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (timeout_s) begin
                    err_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = 32'd0;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    err_d = 1'b0;
                end
            end
            ST_RESP: begin
                cnt_d = cnt_q + 10'd1;
                if (mem.mem_rvalid) begin
                    rdata_d = mem.mem_rdata;
                end else if (timeout_s) begin
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end else begin
                    rdata_d = rdata_q;
                end
            end
            ST_DONE: cnt_d = cnt_q;
            default: cnt_d = cnt_q;
        endcase
    end

    // Datapath registers; err_q/mis_q are set only for the DONE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            strb_q  <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            cnt_q   <= 10'd0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            strb_q  <= strb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    // State-decoded outputs; stall is forced low while reset is asserted.
    always_comb begin
        mem_valid_s  = 1'b0;
        core_valid_s = 1'b0;
        core_stall_s = 1'b0;
        case (state_q)
            ST_IDLE: core_stall_s = core_req_i & rst;
            ST_REQ: begin
                mem_valid_s  = 1'b1;
                core_stall_s = rst;
            end
            ST_RESP: core_stall_s = rst;
            ST_DONE: core_valid_s = 1'b1;
            default: core_stall_s = 1'b0;
        endcase
    end

    assign mem.mem_valid  = mem_valid_s;
    assign mem.mem_we     = we_q;
    assign mem.mem_strb   = strb_q;
    assign mem.mem_addr   = addr_q;
    assign mem.mem_wdata  = wdata_q;

    assign core_rdata_o   = rdata_q;
    assign core_stall_o   = core_stall_s;
    assign core_valid_o   = core_valid_s;
    assign bus_err_o      = err_q;
    assign misalign_o     = mis_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl. The main instance uses the
// default timeout; a second instance with TIMEOUT_CYCLES=4 covers the abort path.
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        core_req;
    logic        core_req2;
    logic        core_we;
    logic [3:0]  core_mask;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;

    logic [31:0] rdata, rdata2;
    logic        stall, stall2;
    logic        cvalid, cvalid2;
    logic        berr, berr2;
    logic        mis, mis2;

    data_mem_ctrl_if bus ();
    data_mem_ctrl_if bus2 ();

    int n_checks;
    int n_fail;
    int n_mvalid;
    int n_cvalid;
    int n_stall;

    data_mem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .core_req_i   (core_req),
        .core_we_re_i (core_we),
        .core_mask_i  (core_mask),
        .core_addr_i  (core_addr),
        .core_wdata_i (core_wdata),
        .core_rdata_o (rdata),
        .core_stall_o (stall),
        .core_valid_o (cvalid),
        .bus_err_o    (berr),
        .misalign_o   (mis),
        .mem          (bus)
    );

    data_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk          (clk),
        .rst          (rst),
        .core_req_i   (core_req2),
        .core_we_re_i (core_we),
        .core_mask_i  (core_mask),
        .core_addr_i  (core_addr),
        .core_wdata_i (core_wdata),
        .core_rdata_o (rdata2),
        .core_stall_o (stall2),
        .core_valid_o (cvalid2),
        .bus_err_o    (berr2),
        .misalign_o   (mis2),
        .mem          (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample the cycle that is ending (main instance), then advance past the edge.
    task automatic tick();
        #1;
        if (bus.mem_valid) n_mvalid++;
        if (cvalid) n_cvalid++;
        if (stall) n_stall++;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        n_mvalid = 0;
        n_cvalid = 0;
        n_stall  = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clr_counts();
        rst = 1'b0;
        core_req = 1'b0; core_req2 = 1'b0; core_we = 1'b0;
        core_mask = 4'd0; core_addr = 32'd0; core_wdata = 32'd0;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
        bus2.mem_ready = 1'b0; bus2.mem_rvalid = 1'b0; bus2.mem_rdata = 32'd0;

        // ---- reset state, stall gated even with a pending request
        #12;
        core_req = 1'b1;
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_mvalid", {31'd0, bus.mem_valid}, 32'd0);
        chk("rst_cvalid", {31'd0, cvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        core_req = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        tick();
        chk("post_rst_idle", {31'd0, bus.mem_valid}, 32'd0);

        // ---- store, ready after 2 wait cycles
        clr_counts();
        core_req = 1'b1; core_we = 1'b1; core_mask = 4'b1111;
        core_addr = 32'h0000_0100; core_wdata = 32'hDEAD_BEEF;
        #1;
        chk("st_stall_idle", {31'd0, stall}, 32'd1);
        tick();
        core_req = 1'b0;
        chk("st_mvalid1", {31'd0, bus.mem_valid}, 32'd1);
        chk("st_addr1", bus.mem_addr, 32'h0000_0100);
        chk("st_wdata1", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("st_we1", {28'd0, bus.mem_we, bus.mem_strb}, 32'h0000_001F);
        tick();
        chk("st_addr2", bus.mem_addr, 32'h0000_0100);
        chk("st_wdata2", bus.mem_wdata, 32'hDEAD_BEEF);
        tick();
        bus.mem_ready = 1'b1;
        chk("st_mvalid3", {31'd0, bus.mem_valid}, 32'd1);
        tick();
        bus.mem_ready = 1'b0;
        chk("st_done_cvalid", {31'd0, cvalid}, 32'd1);
        chk("st_done_stall", {31'd0, stall}, 32'd0);
        chk("st_done_berr", {31'd0, berr}, 32'd0);
        tick();
        chk("st_idle_cvalid", {31'd0, cvalid}, 32'd0);
        chk("st_cnt_mvalid", n_mvalid, 32'd3);
        chk("st_cnt_cvalid", n_cvalid, 32'd1);
        chk("st_cnt_stall", n_stall, 32'd4);

        // ---- load, ready immediate, rvalid 3 cycles after the handshake
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0200;
        bus.mem_ready = 1'b1;
        tick();
        core_req = 1'b0;
        chk("ld_mvalid", {31'd0, bus.mem_valid}, 32'd1);
        tick();
        bus.mem_ready = 1'b0;
        chk("ld_resp_mvalid", {31'd0, bus.mem_valid}, 32'd0);
        chk("ld_resp_stall", {31'd0, stall}, 32'd1);
        tick();
        tick();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
        tick();
        bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0BAD_0BAD;
        chk("ld_done_rdata", rdata, 32'h1234_5678);
        chk("ld_done_cvalid", {31'd0, cvalid}, 32'd1);
        tick();

        // ---- store afterwards leaves core_rdata alone
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h0000_0104;
        core_wdata = 32'h5555_AAAA; bus.mem_ready = 1'b1;
        tick();
        core_req = 1'b0;
        tick();
        bus.mem_ready = 1'b0;
        chk("st2_done_cvalid", {31'd0, cvalid}, 32'd1);
        chk("st2_rdata_kept", rdata, 32'h1234_5678);
        tick();

        // ---- stray rvalid in IDLE is ignored
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
        tick();
        tick();
        bus.mem_rvalid = 1'b0;
        chk("stray_rdata", rdata, 32'h1234_5678);
        chk("stray_cvalid", {31'd0, cvalid}, 32'd0);

        // ---- load with ready and rvalid in the handshake cycle
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0300;
        bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
        tick();
        core_req = 1'b0;
        tick();
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
        chk("same_cyc_cvalid", {31'd0, cvalid}, 32'd1);
        chk("same_cyc_rdata", rdata, 32'hCAFE_F00D);
        tick();

        // ---- empty mask: straight to DONE, no bus cycle
        clr_counts();
        core_req = 1'b1; core_mask = 4'b0000; core_addr = 32'h0000_0310;
        tick();
        core_req = 1'b0;
        chk("m0_cvalid", {31'd0, cvalid}, 32'd1);
        chk("m0_berr", {31'd0, berr}, 32'd0);
        tick();
        chk("m0_no_bus", n_mvalid, 32'd0);
        chk("m0_rdata", rdata, 32'hCAFE_F00D);
        core_mask = 4'b1111;

        // ---- misaligned word access to 0x102
        clr_counts();
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0102;
`ifdef MISALIGN_CHECK_EN
        tick();
        core_req = 1'b0;
        chk("mis_cvalid", {31'd0, cvalid}, 32'd1);
        chk("mis_flag", {31'd0, mis}, 32'd1);
        tick();
        chk("mis_flag_clr", {31'd0, mis}, 32'd0);
        chk("mis_no_bus", n_mvalid, 32'd0);
`else
        bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0102;
        tick();
        core_req = 1'b0;
        chk("mis_bus_valid", {31'd0, bus.mem_valid}, 32'd1);
        chk("mis_bus_addr", bus.mem_addr, 32'h0000_0102);
        tick();
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
        chk("mis_flag_off", {31'd0, mis}, 32'd0);
        chk("mis_cvalid", {31'd0, cvalid}, 32'd1);
        tick();
`endif

        // ---- back-to-back: request held through DONE
        clr_counts();
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h0000_0500;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        chk("b2b_done1", {31'd0, cvalid}, 32'd1);
        tick();
        chk("b2b_idle_cvalid", {31'd0, cvalid}, 32'd0);
        chk("b2b_idle_stall", {31'd0, stall}, 32'd1);
        tick();
        core_req = 1'b0;
        chk("b2b_req2", {31'd0, bus.mem_valid}, 32'd1);
        tick();
        bus.mem_ready = 1'b0;
        tick();
        chk("b2b_cnt_cvalid", n_cvalid, 32'd2);
        chk("b2b_cnt_mvalid", n_mvalid, 32'd2);

        // ---- timeout instance: preload rdata, then a load that never gets ready
        core_req2 = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0600;
        bus2.mem_ready = 1'b1; bus2.mem_rvalid = 1'b1; bus2.mem_rdata = 32'hA5A5_A5A5;
        tick();
        core_req2 = 1'b0;
        tick();
        bus2.mem_ready = 1'b0; bus2.mem_rvalid = 1'b0;
        chk("to_preload", rdata2, 32'hA5A5_A5A5);
        tick();
        core_req2 = 1'b1;
        tick();
        core_req2 = 1'b0;
        tick();
        tick();
        tick();
        chk("to_req4_mvalid", {31'd0, bus2.mem_valid}, 32'd1);
        chk("to_req4_cvalid", {31'd0, cvalid2}, 32'd0);
        chk("to_req4_berr", {31'd0, berr2}, 32'd0);
        tick();
        chk("to_done_cvalid", {31'd0, cvalid2}, 32'd1);
        chk("to_done_berr", {31'd0, berr2}, 32'd1);
        chk("to_done_rdata", rdata2, 32'd0);
        chk("to_done_mvalid", {31'd0, bus2.mem_valid}, 32'd0);
        tick();
        chk("to_idle_berr", {31'd0, berr2}, 32'd0);

        // ---- asynchronous reset while waiting in RESP
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0400;
        bus.mem_ready = 1'b1;
        tick();
        core_req = 1'b0;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        chk("rr_in_resp", {31'd0, stall}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rr_stall", {31'd0, stall}, 32'd0);
        chk("rr_mvalid", {31'd0, bus.mem_valid}, 32'd0);
        chk("rr_rdata", rdata, 32'd0);
        chk("rr_addr", bus.mem_addr, 32'd0);
        #1;
        rst = 1'b1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h7777_7777;
        tick();
        tick();
        bus.mem_rvalid = 1'b0;
        chk("rr_late_rdata", rdata, 32'd0);
        chk("rr_late_cvalid", {31'd0, cvalid}, 32'd0);
        chk("rr_no_issue", {31'd0, bus.mem_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
